joybus_frame_tx: RTL and testbench
==================================

JOYBUS_FRAME_TX -- requirements
Module: joybus_frame_tx

Interface
REQ-001 SHALL have parameter LEVEL_WIDTH, default 2, meaning sample_clk cycles per line level (>=1).
REQ-002 SHALL have parameter MAX_BYTES, default 32, meaning the maximum payload bytes per frame (1..63).
REQ-003 SHALL have port sample_clk  in  1  meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  in  1  meaning an asynchronous, active-high reset.
REQ-005 SHALL have port start  in  1  meaning a one-cycle frame request.
REQ-006 SHALL have port byte_count  in  $clog2(MAX_BYTES+1)  meaning payload length, sampled with start.
REQ-007 SHALL have port tx_byte  in  8  meaning a payload byte, sent MSB first.
REQ-008 SHALL have port tx_byte_valid  in  1  meaning tx_byte is valid.
REQ-009 SHALL have port tx_byte_ready  out  1  meaning the block accepts tx_byte this cycle.
REQ-010 SHALL have port busy  out  1  meaning a frame is in progress.
REQ-011 SHALL have port done  out  1  meaning a one-cycle pulse after the stop bit completes.
REQ-012 SHALL have port underrun  out  1  meaning a one-cycle pulse when a frame is aborted.
REQ-013 SHALL have port data_oe  out  1  meaning open-drain enable: 1 pulls the line low, 0 releases it high.

Function
REQ-014 SHALL implement states IDLE, FETCH, BITS, STOP and DONE.
REQ-015 SHALL, in IDLE, on start=1 with byte_count>0, latch byte_count, clamped to MAX_BYTES, and enter FETCH; start with byte_count=0 SHALL be ignored with no pulses.
REQ-016 SHALL ignore start while busy=1.
REQ-017 SHALL assert busy in all states except IDLE.
REQ-018 SHALL drive tx_byte_ready high whenever the one-byte holding register is empty and unfetched payload bytes remain; a transfer SHALL occur on tx_byte_valid and tx_byte_ready both high.
REQ-019 SHALL wait indefinitely in FETCH for the first byte; data_oe SHALL go high in the cycle after the first transfer, and the FSM SHALL enter BITS.
REQ-020 SHALL encode each bit as 4 levels of LEVEL_WIDTH cycles: logical 0 = L,L,L,H; logical 1 = L,H,H,H (L = data_oe 1).
REQ-021 SHALL transmit bits back-to-back with no gap, so a frame lasts (8*N+1)*4*LEVEL_WIDTH cycles from the first low level.
REQ-022 SHALL load the next byte from the holding register into the shift register at the byte boundary, and then refill tx_byte_ready.
REQ-023 SHALL, if the holding register is empty at a byte boundary, release data_oe, pulse underrun for one cycle, and return to IDLE without a done pulse.
REQ-024 SHALL, after the last payload bit, enter STOP and send L,L,H,H (the H levels released).
REQ-025 SHALL, after STOP, enter DONE for one cycle with done=1, then go to IDLE.
REQ-026 SHALL never assert data_oe outside BITS and STOP.

Reset
REQ-027 SHALL, on reset assertion, force IDLE immediately (asynchronously), including mid-frame.
REQ-028 SHALL hold data_oe, tx_byte_ready, busy, done and underrun at 0 during and after reset.
REQ-029 SHALL clear all counters, the holding register and the shift register on reset.

Configuration
REQ-030 SHALL, with JOYBUS_TX_CRC_EN defined, append one CRC byte after the payload.
REQ-031 SHALL compute that CRC as CRC-8, MSB first, polynomial 0x85, initial value 0x00, no final XOR, over the payload bytes.
REQ-032 SHALL, with JOYBUS_TX_CRC_EN defined, never let the CRC byte cause an underrun, and SHALL extend the frame by 8 bits.
REQ-033 SHALL, without JOYBUS_TX_CRC_EN, contain no CRC logic and frame exactly as in the Function requirements.

Structure
REQ-034 SHALL take the state encodings, the level patterns for 0, 1 and stop, and the CRC polynomial constant from shared package joybus_pkg.
REQ-035 SHALL put the level/bit timing (level counter and 4-level pattern shifter) in sub-module joybus_bit_serializer.

Verification
REQ-036 SHALL verify that with LEVEL_WIDTH=2, start with byte_count=3 and bytes 0x05,0x00,0x00 offered immediately -> 200 cycles of activity, first bit data_oe pattern 1,1,1,1,1,1,0,0, done pulses once.
REQ-037 SHALL verify that byte 0xFF followed by a stop bit -> each bit is data_oe 1,1 then 0 for six cycles; the stop bit is 1,1,1,1,0,0,0,0.
REQ-038 SHALL verify that with byte_count=2 and the second byte withheld -> underrun pulses exactly at the first byte boundary, data_oe=0, busy=0, and no done pulse.
REQ-039 SHALL verify that reset asserted during bit 5 -> data_oe and busy are 0 in the same cycle, and a later start sends a full, correct frame.
REQ-040 SHALL verify that start with byte_count=0, or start while busy -> no state change and no pulses.
REQ-041 SHALL verify that with JOYBUS_TX_CRC_EN and payload 0x01 -> the appended CRC byte is 0x85, in a 17-bit frame.

Source files
------------

// File: rtl/joybus_pkg.sv
// Shared constants for the Joybus frame transmitter: FSM states, per-bit level
// patterns and the CRC-8 helper (CRC only built with JOYBUS_TX_CRC_EN).
package joybus_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    BITS  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Four line levels per bit, first level in the MSB; a 1 means "pull low".
  localparam logic [3:0] PAT_ZERO = 4'b1110;  // L,L,L,H
  localparam logic [3:0] PAT_ONE  = 4'b1000;  // L,H,H,H
  localparam logic [3:0] PAT_STOP = 4'b1100;  // L,L,H,H

  localparam logic [7:0] CRC_POLY = 8'h85;

  function automatic logic [3:0] bit_pattern(input logic b);
    return b ? PAT_ONE : PAT_ZERO;
  endfunction

`ifdef JOYBUS_TX_CRC_EN
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction
`endif

endpackage

// File: rtl/joybus_frame_tx_if.sv
// Request, payload handshake and line/status signals of joybus_frame_tx.
interface joybus_frame_tx_if #(
  parameter int MAX_BYTES = 32
);
  localparam int CW = $clog2(MAX_BYTES + 1);

  logic          start;
  logic [CW-1:0] byte_count;
  logic [7:0]    tx_byte;
  // A byte moves on every rising edge where tx_byte_valid and tx_byte_ready are
  // both high; the source holds tx_byte stable while valid is high and unaccepted.
  logic          tx_byte_valid;
  logic          tx_byte_ready;
  logic          busy;
  logic          done;
  logic          underrun;
  logic          data_oe;

  modport master (
    output start, byte_count, tx_byte, tx_byte_valid,
    input  tx_byte_ready, busy, done, underrun, data_oe
  );

  modport slave (
    input  start, byte_count, tx_byte, tx_byte_valid,
    output tx_byte_ready, busy, done, underrun, data_oe
  );
endinterface

// File: rtl/joybus_bit_serializer.sv
// Plays one 4-level bit pattern, each level LEVEL_WIDTH cycles; bit_last marks
// the final cycle so the next pattern can be loaded back-to-back.
module joybus_bit_serializer #(
  parameter int LEVEL_WIDTH = 2
) (
  input  logic       sample_clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] pattern,
  output logic       oe,
  output logic       bit_last
);
  localparam int LCW = (LEVEL_WIDTH > 1) ? $clog2(LEVEL_WIDTH) : 1;

  logic [LCW-1:0] lvl_cnt;
  logic [1:0]     lvl_idx;
  logic [3:0]     pat;
  logic           active;
  logic           lvl_last;

  assign lvl_last = (lvl_cnt == LCW'(LEVEL_WIDTH - 1));
  assign bit_last = active && lvl_last && (lvl_idx == 2'd3);
  assign oe       = active && pat[3];

  always_ff @(posedge sample_clk or posedge reset) begin
    if (reset) begin
      lvl_cnt <= '0;
      lvl_idx <= '0;
      pat     <= '0;
      active  <= 1'b0;
    end else if (load) begin
      lvl_cnt <= '0;
      lvl_idx <= '0;
      pat     <= pattern;
      active  <= 1'b1;
    end else if (active) begin
      if (lvl_last) begin
        lvl_cnt <= '0;
        if (lvl_idx == 2'd3) begin
          active <= 1'b0;
        end else begin
          lvl_idx <= lvl_idx + 2'd1;
          pat     <= {pat[2:0], 1'b0};
        end
      end else begin
        lvl_cnt <= lvl_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/joybus_frame_tx.sv
// Joybus frame transmitter: fetches payload bytes over valid/ready and drives the
// open-drain line MSB first, then a stop bit. JOYBUS_TX_CRC_EN appends a CRC-8 byte.
module joybus_frame_tx
  import joybus_pkg::*;
#(
  parameter int LEVEL_WIDTH = 2,
  parameter int MAX_BYTES   = 32
) (
  input  logic             sample_clk,
  input  logic             reset,
  joybus_frame_tx_if.slave bus,
  output state_t           dbg_state
);
  localparam int CW = $clog2(MAX_BYTES + 1);

  state_t        state, next_state;
  logic [CW-1:0] frame_len, fetched, sent, len_in;
  logic [2:0]    bit_idx;
  logic [7:0]    shift, hold;
  logic          hold_full, underrun_q;
  logic          ready, xfer;
  logic          ser_load, ser_oe, ser_last;
  logic [3:0]    ser_pattern;
  logic          first_load, bypass_load, hold_load, next_bit, abort, frame_end;

`ifdef JOYBUS_TX_CRC_EN
  logic [7:0] crc;
  logic       crc_sent, crc_load;
  assign frame_end = crc_sent;
`else
  assign frame_end = (sent == frame_len);
`endif

  assign len_in = (bus.byte_count > CW'(MAX_BYTES)) ? CW'(MAX_BYTES) : bus.byte_count;
  assign ready  = ((state == FETCH) || (state == BITS)) && !hold_full && (fetched != frame_len);
  assign xfer   = ready && bus.tx_byte_valid;

  assign bus.tx_byte_ready = ready;
  assign bus.busy          = (state != IDLE);
  assign bus.done          = (state == DONE);
  assign bus.underrun      = underrun_q;
  assign bus.data_oe       = ser_oe && ((state == BITS) || (state == STOP));
  assign dbg_state         = state;

  joybus_bit_serializer #(.LEVEL_WIDTH(LEVEL_WIDTH)) u_ser (
    .sample_clk (sample_clk),
    .reset      (reset),
    .load       (ser_load),
    .pattern    (ser_pattern),
    .oe         (ser_oe),
    .bit_last   (ser_last)
  );

  always_ff @(posedge sample_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    ser_load    = 1'b0;
    ser_pattern = PAT_ZERO;
    first_load  = 1'b0;
    bypass_load = 1'b0;
    hold_load   = 1'b0;
    next_bit    = 1'b0;
    abort       = 1'b0;
`ifdef JOYBUS_TX_CRC_EN
    crc_load    = 1'b0;
`endif
    case (state)
      IDLE: if (bus.start && (bus.byte_count != '0)) next_state = FETCH;
      FETCH: if (xfer) begin
        first_load  = 1'b1;
        ser_load    = 1'b1;
        ser_pattern = bit_pattern(bus.tx_byte[7]);
        next_state  = BITS;
      end
      BITS: if (ser_last) begin
        ser_load = 1'b1;
        if (bit_idx != 3'd7) begin
          next_bit    = 1'b1;
          ser_pattern = bit_pattern(shift[6]);
        end else if (frame_end) begin
          ser_pattern = PAT_STOP;
          next_state  = STOP;
        end
`ifdef JOYBUS_TX_CRC_EN
        else if (sent == frame_len) begin
          crc_load    = 1'b1;
          ser_pattern = bit_pattern(crc[7]);
        end
`endif
        else if (hold_full) begin
          hold_load   = 1'b1;
          ser_pattern = bit_pattern(hold[7]);
        end else if (xfer) begin
          // Byte arriving exactly on the boundary goes straight to the shifter.
          bypass_load = 1'b1;
          ser_pattern = bit_pattern(bus.tx_byte[7]);
        end else begin
          ser_load   = 1'b0;
          abort      = 1'b1;
          next_state = IDLE;
        end
      end
      STOP:    if (ser_last) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge sample_clk or posedge reset) begin
    if (reset) begin
      frame_len  <= '0;
      fetched    <= '0;
      sent       <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      underrun_q <= 1'b0;
`ifdef JOYBUS_TX_CRC_EN
      crc        <= '0;
      crc_sent   <= 1'b0;
`endif
    end else begin
      underrun_q <= abort;
      if ((state == IDLE) && (next_state == FETCH)) begin
        frame_len <= len_in;
        fetched   <= '0;
        sent      <= '0;
        hold_full <= 1'b0;
`ifdef JOYBUS_TX_CRC_EN
        crc       <= '0;
        crc_sent  <= 1'b0;
`endif
      end
      if (xfer) begin
        fetched <= fetched + 1'b1;
`ifdef JOYBUS_TX_CRC_EN
        crc     <= crc8_byte(crc, bus.tx_byte);
`endif
        if (!first_load && !bypass_load) begin
          hold      <= bus.tx_byte;
          hold_full <= 1'b1;
        end
      end
      if (first_load || bypass_load) begin
        shift   <= bus.tx_byte;
        bit_idx <= '0;
        sent    <= sent + 1'b1;
      end
      if (hold_load) begin
        shift     <= hold;
        hold_full <= 1'b0;
        bit_idx   <= '0;
        sent      <= sent + 1'b1;
      end
`ifdef JOYBUS_TX_CRC_EN
      if (crc_load) begin
        shift    <= crc;
        crc_sent <= 1'b1;
        bit_idx  <= '0;
      end
`endif
      if (next_bit) begin
        shift   <= {shift[6:0], 1'b0};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_joybus_frame_tx.sv
// Bench for joybus_frame_tx: a line monitor decodes data_oe back into bytes and
// frame end events and checks them against a queue filled by the stimulus side.
`timescale 1ns/1ps
module tb_joybus_frame_tx;
  import joybus_pkg::*;

  localparam int LW   = 2;
  localparam int MAXB = 6;
  localparam int CW   = $clog2(MAXB + 1);
  localparam int BITC = 4 * LW;
  localparam logic EV_DONE     = 1'b0;
  localparam logic EV_UNDERRUN = 1'b1;

  // ---------------- clock / reset ----------------
  logic   clk   = 1'b0;
  logic   reset = 1'b1;
  state_t dbg_state;
  always #5 clk = ~clk;

  joybus_frame_tx_if #(.MAX_BYTES(MAXB)) bus ();

  joybus_frame_tx #(.LEVEL_WIDTH(LW), .MAX_BYTES(MAXB)) dut (
    .sample_clk (clk),
    .reset      (reset),
    .bus        (bus),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cycle    = 0;
  int mon_fstart = 0;
  logic [7:0]      exp_q[$];
  logic            ev_q[$];
  logic [7:0]      pay_q[$];
  logic [BITC-1:0] vec_zero, vec_one, vec_stop, first_vec, stop_vec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string detail);
    n_checks++;
    n_errors++;
    $display("FAIL %s: %s", name, detail);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [BITC-1:0] levels(input string s);
    logic [BITC-1:0] v;
    v = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < LW; j++)
        v = {v[BITC-2:0], (s[i] == "L")};
    return v;
  endfunction

  // Long division of message * x^8 by x^8+x^7+x^2+1.
  function automatic logic [7:0] model_crc(input logic [7:0] msg[$]);
    logic [8:0] r;
    logic       b;
    r = '0;
    for (int i = 0; i < msg.size() + 1; i++)
      for (int k = 7; k >= 0; k--) begin
        b = (i < msg.size()) ? msg[i][k] : 1'b0;
        r = {r[7:0], b};
        if (r[8]) r = r ^ 9'h185;
      end
    return r[7:0];
  endfunction

  task automatic expect_frame(input int n);
    logic [7:0] sent_q[$];
    int nb;
    nb = (n > MAXB) ? MAXB : n;
    for (int i = 0; i < nb; i++) begin
      exp_q.push_back(pay_q[i]);
      sent_q.push_back(pay_q[i]);
    end
`ifdef JOYBUS_TX_CRC_EN
    exp_q.push_back(model_crc(sent_q));
`endif
    ev_q.push_back(EV_DONE);
  endtask

  // ---------------- driver ----------------
  task automatic send_frame(input int n, input int gap_max, input int give);
    int nb, t;
    nb = (n > MAXB) ? MAXB : n;
    if (give < nb) nb = give;
    @(negedge clk);
    bus.start = 1'b1;
    bus.byte_count = CW'(n);
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < nb; i++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      bus.tx_byte = pay_q[i];
      bus.tx_byte_valid = 1'b1;
      t = 0;
      while (!bus.tx_byte_ready && t < 3000) begin
        @(negedge clk);
        t++;
      end
      if (!bus.tx_byte_ready) begin
        fail("ready_timeout", $sformatf("byte %0d never accepted, expected ready within 3000 cycles", i));
        bus.tx_byte_valid = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
      bus.tx_byte_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    int t;
    t = 0;
    while ((ev_q.size() != 0 || bus.busy) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("drain_in_budget", 32'(t < budget), 1);
    @(negedge clk);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [BITC-1:0] samp;
    logic [7:0]      cur;
    int scnt, nbits, nbytes;
    bit in_frame, first;
    scnt = 0; nbits = 0; nbytes = 0; in_frame = 0; first = 0; cur = '0; samp = '0;
    forever begin
      @(negedge clk);
      cycle++;
      if (reset) begin
        scnt = 0; nbits = 0; nbytes = 0; in_frame = 0;
      end else begin
        if (bus.data_oe)       check("oe_implies_busy", bus.busy, 1);
        if (bus.tx_byte_ready) check("ready_implies_busy", bus.busy, 1);
        if (scnt == 0 && bus.data_oe) begin
          if (!in_frame) begin
            in_frame = 1; mon_fstart = cycle; nbits = 0; nbytes = 0; first = 1;
          end
          scnt = 1;
          samp = {{(BITC-1){1'b0}}, 1'b1};
        end else if (scnt > 0) begin
          samp = {samp[BITC-2:0], bus.data_oe};
          scnt++;
        end
        if (scnt == BITC) begin
          scnt = 0;
          if (first) begin first_vec = samp; first = 0; end
          if (samp == vec_zero || samp == vec_one) begin
            cur = {cur[6:0], (samp == vec_one)};
            nbits++;
            if (nbits == 8) begin
              nbits = 0;
              nbytes++;
              if (exp_q.size() == 0) fail("byte_unexpected", $sformatf("got byte 0x%0h, expected none", cur));
              else check("line_byte", cur, exp_q.pop_front());
            end
          end else if (samp == vec_stop) begin
            stop_vec = samp;
            check("stop_on_byte_boundary", nbits, 0);
          end else begin
            fail("level_pattern", $sformatf("got %b, expected %b, %b or %b", samp, vec_zero, vec_one, vec_stop));
          end
        end
        if (bus.done) begin
          if (ev_q.size() == 0) fail("done_unexpected", "got done pulse, expected none");
          else check("end_event_done", ev_q.pop_front(), EV_DONE);
          check("frame_cycles", cycle - mon_fstart, (8 * nbytes + 1) * BITC);
          in_frame = 0;
        end
        if (bus.underrun) begin
          if (ev_q.size() == 0) fail("underrun_unexpected", "got underrun pulse, expected none");
          else check("end_event_underrun", ev_q.pop_front(), EV_UNDERRUN);
          check("underrun_cycle", cycle - mon_fstart, nbytes * 8 * BITC);
          check("underrun_oe", bus.data_oe, 0);
          check("underrun_busy", bus.busy, 0);
          in_frame = 0; scnt = 0; nbits = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation still running after 2ms, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    int n, t;
    vec_zero = levels("LLLH");
    vec_one  = levels("LHHH");
    vec_stop = levels("LLHH");
    bus.start = 1'b0; bus.byte_count = '0; bus.tx_byte = '0; bus.tx_byte_valid = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_oe", bus.data_oe, 0);
    check("rst_ready", bus.tx_byte_ready, 0);
    check("rst_done", bus.done, 0);
    check("rst_underrun", bus.underrun, 0);
    check("rst_state", dbg_state, IDLE);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_busy", bus.busy, 0);

    // Three bytes offered immediately: 200-cycle frame, first bit a zero.
    pay_q = '{8'h05, 8'h00, 8'h00};
    expect_frame(3);
    send_frame(3, 0, 3);
    wait_idle(600);
    check("first_bit_zero_vec", first_vec, 8'b11111100);

    // All-ones byte and stop bit shapes.
    pay_q = '{8'hFF};
    expect_frame(1);
    send_frame(1, 0, 1);
    wait_idle(300);
    check("first_bit_one_vec", first_vec, 8'b11000000);
    check("stop_vec", stop_vec, 8'b11110000);

    // Zero-length start is ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.byte_count = '0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("zero_len_busy", bus.busy, 0);
    check("zero_len_state", dbg_state, IDLE);

    // Start while busy is ignored; frame must complete unchanged.
    pay_q = '{8'h3C, 8'hA1, 8'h7E};
    expect_frame(3);
    fork
      send_frame(3, 1, 3);
      begin
        repeat (30) @(negedge clk);
        bus.start = 1'b1; bus.byte_count = CW'(2);
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_during_restart", bus.busy, 1);
      end
    join
    wait_idle(600);

    // Second byte withheld: underrun at the first byte boundary.
    pay_q = '{8'hA5, 8'h3C};
    exp_q.push_back(8'hA5);
    ev_q.push_back(EV_UNDERRUN);
    send_frame(2, 0, 1);
    wait_idle(400);
    check("after_underrun_ready", bus.tx_byte_ready, 0);

    // Reset during bit 5, then a clean frame.
    pay_q = '{8'hC3, 8'h5A};
    exp_q.push_back(8'hC3);
    send_frame(2, 0, 2);
    t = 0;
    while (cycle < mon_fstart + 5 * BITC + 3 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("reach_bit5", 32'(t < 500), 1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_oe", bus.data_oe, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_ready", bus.tx_byte_ready, 0);
    exp_q.delete();
    ev_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    pay_q = '{8'hC3, 8'h5A};
    expect_frame(2);
    send_frame(2, 0, 2);
    wait_idle(400);

`ifdef JOYBUS_TX_CRC_EN
    // Single 0x01 payload carries CRC 0x85 in a 17-bit frame.
    pay_q = '{8'h01};
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h85);
    ev_q.push_back(EV_DONE);
    send_frame(1, 0, 1);
    wait_idle(400);
`endif

    // Randomized frames, including lengths above MAX_BYTES.
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(1, MAXB + 1);
      pay_q.delete();
      for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom_range(0, 255)));
      expect_frame(n);
      send_frame(n, 3, n);
      wait_idle(1000);
    end

    check("exp_q_drained", exp_q.size(), 0);
    check("ev_q_drained", ev_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
